// File: rtl/alu_issue_arbiter.sv
// alu_issue_arbiter: round-robin issue of micro-ops from NUM_REQ requesters into
// a single ALU pipeline. A tag FIFO records each issuer so that every pipeline
// result is steered back to the requester that issued it. The number of ops in
// flight is capped at MAX_INFLIGHT.
// A micro-op is an opaque MOP_W-bit vector.
// Optional feature: define ALU_ARB_PERF_EN to add the per-requester grant
// counters on output perf_grant_cnt.
module alu_issue_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int MAX_INFLIGHT = 4,
  parameter int MOP_W        = 32,
  parameter int IDX_W        = $clog2(NUM_REQ)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ-1:0][MOP_W-1:0]   req_mop,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic                            alu_in_ready,
  output logic [MOP_W-1:0]                alu_in_mop,
  input  logic                            alu_busy,
  input  logic                            alu_out_ready,
  input  logic [MOP_W-1:0]                alu_out_mop,
  output logic [NUM_REQ-1:0]              rsp_valid,
  output logic [MOP_W-1:0]                rsp_mop,
  output logic [$clog2(MAX_INFLIGHT):0]   inflight,
  output logic                            tag_err
`ifdef ALU_ARB_PERF_EN
  ,
  output logic [NUM_REQ-1:0][31:0]        perf_grant_cnt
`endif
);

  localparam int AW = $clog2(MAX_INFLIGHT);
  localparam int CW = AW + 1;

  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             tag_err_q, tag_err_d;
  logic [IDX_W-1:0] tag_mem_q [MAX_INFLIGHT];

  logic             fifo_empty, fifo_full, can_issue, found, issue, pop;
  logic [IDX_W-1:0] win, head;
  int unsigned      idx;

  // Arbitration, issue, return steering and next-state computation
  always_comb begin
    fifo_empty = (wr_ptr_q == rd_ptr_q);
    fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    // A pop in this cycle frees a slot, so a full FIFO can still accept an issue.
    can_issue  = !alu_busy && (!fifo_full || alu_out_ready);

    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (32'(rr_ptr_q) + k) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = idx[IDX_W-1:0];
      end
    end

    issue = reset && can_issue && found;
    pop   = reset && alu_out_ready && !fifo_empty;
    head  = tag_mem_q[rd_ptr_q[AW-1:0]];

    req_ready = '0;
    if (issue) req_ready[win] = 1'b1;
    alu_in_ready = issue;
    alu_in_mop   = issue ? req_mop[win] : '0;

    rsp_valid = '0;
    if (pop) rsp_valid[head] = 1'b1;
    rsp_mop = alu_out_mop;

    rr_ptr_d = rr_ptr_q;
    if (issue) rr_ptr_d = (win == IDX_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
    wr_ptr_d  = wr_ptr_q + CW'(issue);
    rd_ptr_d  = rd_ptr_q + CW'(pop);
    tag_err_d = tag_err_q || (alu_out_ready && fifo_empty);

    inflight = wr_ptr_q - rd_ptr_q;
    tag_err  = tag_err_q;
  end

  // Arbiter pointer, FIFO pointers and sticky error flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      tag_err_q <= 1'b0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      tag_err_q <= tag_err_d;
    end
  end

  // Tag storage needs no reset: entries are only read between push and pop
  always_ff @(posedge clk) begin
    if (issue) tag_mem_q[wr_ptr_q[AW-1:0]] <= win;
  end

`ifdef ALU_ARB_PERF_EN
  logic [NUM_REQ-1:0][31:0] perf_q, perf_d;

  // Saturating per-requester grant counters
  always_comb begin
    perf_d = perf_q;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i] && req_valid[i] && (perf_q[i] != '1)) perf_d[i] = perf_q[i] + 32'd1;
    end
    perf_grant_cnt = perf_q;
  end

  // Grant counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) perf_q <= '0;
    else        perf_q <= perf_d;
  end
`endif

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Self-checking bench for alu_issue_arbiter: directed vector table, hand-written
// multi-cycle sequences, then randomized traffic against a queue-based model.
module tb_alu_issue_arbiter;

  localparam int N    = 4;
  localparam int MAXI = 4;
  localparam int W    = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic [N-1:0]     req_valid;
  logic [N-1:0][W-1:0] req_mop;
  logic [N-1:0]     req_ready;
  logic             alu_in_ready;
  logic [W-1:0]     alu_in_mop;
  logic             alu_busy;
  logic             alu_out_ready;
  logic [W-1:0]     alu_out_mop;
  logic [N-1:0]     rsp_valid;
  logic [W-1:0]     rsp_mop;
  logic [2:0]       inflight;
  logic             tag_err;
`ifdef ALU_ARB_PERF_EN
  logic [N-1:0][31:0] perf_grant_cnt;
`endif

  int tests  = 0;
  int failed = 0;

  alu_issue_arbiter #(.NUM_REQ(N), .MAX_INFLIGHT(MAXI), .MOP_W(W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_mop(req_mop), .req_ready(req_ready),
    .alu_in_ready(alu_in_ready), .alu_in_mop(alu_in_mop),
    .alu_busy(alu_busy), .alu_out_ready(alu_out_ready), .alu_out_mop(alu_out_mop),
    .rsp_valid(rsp_valid), .rsp_mop(rsp_mop), .inflight(inflight), .tag_err(tag_err)
`ifdef ALU_ARB_PERF_EN
    , .perf_grant_cnt(perf_grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] valid;
    logic       busy;
    logic       out_rdy;
    logic [3:0] exp_ready;
    logic [3:0] exp_rsp;
    int         exp_inflight;
    logic       exp_err;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] v, input logic b, input logic o);
    req_valid     = v;
    alu_busy      = b;
    alu_out_ready = o;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    drive(4'b0000, 1'b0, 1'b0);
    tick();
    tick();
    reset = 1'b1;
  endtask

  // reference model state
  int mq[$];
  int m_rr;
  bit m_err;

  initial begin
    bit [3:0] rdy_exp, rsp_exp;
    logic [W-1:0] mop_exp;
    bit can, iss, pop;
    int w, idx;

    for (int i = 0; i < N; i++) req_mop[i] = 32'hA0 + i;
    alu_out_mop = 32'h0;
    reset = 1'b0;
    drive(4'b1111, 1'b0, 1'b1);
    #3;
    // reset state with requests and a result strobe pending
    chk("rst_req_ready", req_ready, 0);
    chk("rst_alu_in_ready", alu_in_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_inflight", inflight, 0);
    chk("rst_tag_err", tag_err, 0);
    do_reset();

    // T1: reset mid-traffic
    drive(4'b1111, 1'b0, 1'b0);
    tick(); tick(); tick();
    chk("t1_inflight3", inflight, 3);
    reset = 1'b0;
    #4;
    chk("t1_inflight_rst", inflight, 0);
    chk("t1_ready_rst", req_ready, 0);
    chk("t1_err_rst", tag_err, 0);
    tick();
    reset = 1'b1;
    #4;
    chk("t1_grant_after_release", req_ready, 4'b0001);
    tick();
    do_reset();

    // directed table: sparse requests, busy, return steering, empty pop
    vecs[0] = '{4'b1010, 1'b0, 1'b0, 4'b0010, 4'b0000, 0, 1'b0};
    vecs[1] = '{4'b1010, 1'b0, 1'b0, 4'b1000, 4'b0000, 1, 1'b0};
    vecs[2] = '{4'b1010, 1'b0, 1'b1, 4'b0010, 4'b0010, 2, 1'b0};
    vecs[3] = '{4'b1111, 1'b1, 1'b1, 4'b0000, 4'b1000, 2, 1'b0};
    vecs[4] = '{4'b1111, 1'b1, 1'b1, 4'b0000, 4'b0010, 1, 1'b0};
    vecs[5] = '{4'b0000, 1'b0, 1'b1, 4'b0000, 4'b0000, 0, 1'b0};
    vecs[6] = '{4'b0100, 1'b0, 1'b1, 4'b0100, 4'b0000, 0, 1'b1};
    vecs[7] = '{4'b0000, 1'b0, 1'b1, 4'b0000, 4'b0100, 1, 1'b1};
    vecs[8] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 0, 1'b1};
    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].valid, vecs[i].busy, vecs[i].out_rdy);
      #4;
      chk($sformatf("vec%0d_ready", i), req_ready, vecs[i].exp_ready);
      chk($sformatf("vec%0d_in_ready", i), alu_in_ready, |vecs[i].exp_ready);
      chk($sformatf("vec%0d_rsp", i), rsp_valid, vecs[i].exp_rsp);
      chk($sformatf("vec%0d_inflight", i), inflight, vecs[i].exp_inflight);
      chk($sformatf("vec%0d_err", i), tag_err, vecs[i].exp_err);
      tick();
    end
    do_reset();

    // T4: fill to MAX_INFLIGHT, then a pop lets an issue through in the same cycle
    for (int c = 0; c < 4; c++) begin
      drive(4'b1111, 1'b0, 1'b0);
      #4;
      chk("t4_fill_grant", req_ready, 4'b0001 << c);
      chk("t4_fill_mop", alu_in_mop, 32'hA0 + c);
      tick();
    end
    #4;
    chk("t4_full_ready", req_ready, 0);
    chk("t4_full_inflight", inflight, 4);
    alu_out_ready = 1'b1;
    #1;
    chk("t4_pop_grant", req_ready, 4'b0001);
    chk("t4_pop_rsp", rsp_valid, 4'b0001);
    alu_out_ready = 1'b0;
    req_valid = 4'b0000;
    alu_out_ready = 1'b1;
    req_valid = 4'b1111;
    tick();
    alu_out_ready = 1'b0;
    #4;
    chk("t4_inflight_stays", inflight, 4);
    chk("t4_err_clear", tag_err, 0);
    do_reset();

    // T2: all requesting, results looped back two cycles after issue
    for (int c = 0; c < 10; c++) begin
      drive((c < 8) ? 4'b1111 : 4'b0000, 1'b0, (c >= 2));
      alu_out_mop = 32'h5000 + c;
      #4;
      if (c < 8) chk("t2_grant", req_ready, 4'b0001 << (c % 4));
      else       chk("t2_no_grant", req_ready, 0);
      if (c >= 2) chk("t2_rsp", rsp_valid, 4'b0001 << ((c - 2) % 4));
      chk("t2_rsp_mop", rsp_mop, 32'h5000 + c);
      tick();
    end
    #4;
    chk("t2_drained", inflight, 0);
    chk("t2_no_err", tag_err, 0);

`ifdef ALU_ARB_PERF_EN
    do_reset();
    for (int c = 0; c < 5; c++) begin
      drive(4'b0100, 1'b0, 1'b1);
      tick();
    end
    drive(4'b0000, 1'b0, 1'b0);
    #4;
    for (int i = 0; i < N; i++) chk("t6_perf", perf_grant_cnt[i], (i == 2) ? 5 : 0);
`endif

    // randomized traffic against the queue model
    do_reset();
    mq.delete();
    m_rr  = 0;
    m_err = 0;
    for (int c = 0; c < 1500; c++) begin
      req_valid     = 4'($urandom);
      alu_busy      = ($urandom % 4) == 0;
      alu_out_ready = ($urandom % 5) < 2;
      alu_out_mop   = $urandom;
      for (int j = 0; j < N; j++) req_mop[j] = $urandom;

      can = !alu_busy && (mq.size() < MAXI || alu_out_ready);
      w = -1;
      for (int k = 0; k < N; k++) begin
        idx = (m_rr + k) % N;
        if (w < 0 && req_valid[idx]) w = idx;
      end
      iss = can && (w >= 0);
      pop = alu_out_ready && (mq.size() > 0);
      rdy_exp = iss ? (4'b0001 << w) : 4'b0000;
      rsp_exp = pop ? (4'b0001 << mq[0]) : 4'b0000;
      mop_exp = iss ? req_mop[w] : '0;

      #4;
      chk("rnd_ready", req_ready, rdy_exp);
      chk("rnd_in_ready", alu_in_ready, iss);
      chk("rnd_in_mop", alu_in_mop, mop_exp);
      chk("rnd_rsp", rsp_valid, rsp_exp);
      chk("rnd_rsp_mop", rsp_mop, alu_out_mop);
      chk("rnd_inflight", inflight, mq.size());
      chk("rnd_err", tag_err, m_err);

      @(posedge clk);
      if (pop) void'(mq.pop_front());
      if (alu_out_ready && !pop) m_err = 1;
      if (iss) begin
        mq.push_back(w);
        m_rr = (w + 1) % N;
      end
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
